// File: rtl/multicycle_adder.sv
// multicycle_adder: WIDTH-bit ripple adder/subtractor that adds CHUNK bits per clock
// over N = WIDTH/CHUNK RUN cycles, with a start/busy/done handshake and status flags.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   start             request, accepted in IDLE or in the DONE cycle
//   sub, a, b, cin    operation and operands, captured on accept
//   busy, done        computation in progress / one-cycle result-valid pulse
//   sum, cout         result and MSB carry-out (for subtract, 1 = no borrow)
//   overflow, zero    signed overflow and sum == 0, updated on entry to DONE
module multicycle_adder #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned N  = WIDTH / CHUNK;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [KW-1:0]    k;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc;
    logic             carry;

    logic             accept_c;
    logic             last_c;
    logic [31:0]      base_c;
    logic [CHUNK:0]   chunk_sum_c;
    logic [WIDTH-1:0] acc_next_c;

    // Chunk adder and partial-result merge for the current RUN cycle
    always_comb begin
        accept_c    = start && ((state == IDLE) || (state == DONE));
        last_c      = (k == KW'(N - 1));
        base_c      = 32'(k) * CHUNK;
        chunk_sum_c = {1'b0, a_q[base_c +: CHUNK]} + {1'b0, b_q[base_c +: CHUNK]}
                      + (CHUNK + 1)'(carry);
        acc_next_c  = acc;
        acc_next_c[base_c +: CHUNK] = chunk_sum_c[CHUNK-1:0];
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = RUN;
            RUN:     if (last_c) state_next = DONE;
            DONE:    state_next = accept_c ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath, handshake outputs and result flags
    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            k        <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
        end else begin
            busy <= (state_next == RUN);
            done <= (state_next == DONE);
            if (accept_c) begin
                a_q   <= a;
                b_q   <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                k     <= '0;
            end else if (state == RUN) begin
                acc   <= acc_next_c;
                carry <= chunk_sum_c[CHUNK];
                k     <= k + KW'(1);
                // Published result changes only when the last chunk lands
                if (last_c) begin
                    sum      <= acc_next_c;
                    cout     <= chunk_sum_c[CHUNK];
                    overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                (acc_next_c[WIDTH-1] != a_q[WIDTH-1]);
                    zero     <= ~|acc_next_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: directed and random checks of multicycle_adder across several
// WIDTH/CHUNK configurations, with a scoreboard queue of expected results.
module tb_multicycle_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    // Instance configurations: 0:(1,1) 1:(32,8) 2:(8,2) 3:(32,1) 4:(32,4) 5:(32,32)
    localparam int W_T [6] = '{1, 32, 8, 32, 32, 32};
    localparam int N_T [6] = '{1, 4, 4, 32, 8, 1};

    logic        clk = 1'b0;
    logic        reset;
    logic        sub;
    logic        cin;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  start_v;

    logic        busy_o [6];
    logic        done_o [6];
    logic [31:0] sum_o  [6];
    logic        cout_o [6];
    logic        ovf_o  [6];
    logic        zero_o [6];

    logic [0:0]  s0;
    logic [31:0] s1;
    logic [7:0]  s2;
    logic [31:0] s3;
    logic [31:0] s4;
    logic [31:0] s5;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    multicycle_adder #(.WIDTH(1), .CHUNK(1)) u0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .sub(sub), .a(a[0:0]), .b(b[0:0]),
        .cin(cin), .busy(busy_o[0]), .done(done_o[0]), .sum(s0), .cout(cout_o[0]),
        .overflow(ovf_o[0]), .zero(zero_o[0]));
    multicycle_adder #(.WIDTH(32), .CHUNK(8)) u1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy_o[1]), .done(done_o[1]), .sum(s1), .cout(cout_o[1]),
        .overflow(ovf_o[1]), .zero(zero_o[1]));
    multicycle_adder #(.WIDTH(8), .CHUNK(2)) u2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .busy(busy_o[2]), .done(done_o[2]), .sum(s2), .cout(cout_o[2]),
        .overflow(ovf_o[2]), .zero(zero_o[2]));
    multicycle_adder #(.WIDTH(32), .CHUNK(1)) u3 (
        .clk(clk), .reset(reset), .start(start_v[3]), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy_o[3]), .done(done_o[3]), .sum(s3), .cout(cout_o[3]),
        .overflow(ovf_o[3]), .zero(zero_o[3]));
    multicycle_adder #(.WIDTH(32), .CHUNK(4)) u4 (
        .clk(clk), .reset(reset), .start(start_v[4]), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy_o[4]), .done(done_o[4]), .sum(s4), .cout(cout_o[4]),
        .overflow(ovf_o[4]), .zero(zero_o[4]));
    multicycle_adder #(.WIDTH(32), .CHUNK(32)) u5 (
        .clk(clk), .reset(reset), .start(start_v[5]), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy_o[5]), .done(done_o[5]), .sum(s5), .cout(cout_o[5]),
        .overflow(ovf_o[5]), .zero(zero_o[5]));

    assign sum_o[0] = 32'(s0);
    assign sum_o[1] = s1;
    assign sum_o[2] = 32'(s2);
    assign sum_o[3] = s3;
    assign sum_o[4] = s4;
    assign sum_o[5] = s5;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-word reference: operands masked to w bits, added in 64-bit arithmetic
    function automatic exp_t ref_model(input int w, input logic [31:0] ai, input logic [31:0] bi,
                                       input logic ci, input logic si);
        exp_t        e;
        logic [63:0] m;
        logic [31:0] bb;
        logic [63:0] r;
        m      = (64'd1 << w) - 64'd1;
        bb     = (si ? ~bi : bi) & m[31:0];
        r      = {32'd0, ai & m[31:0]} + {32'd0, bb} + 64'(si ? 1'b1 : ci);
        e.sum  = r[31:0] & m[31:0];
        e.cout = r[w];
        e.ovf  = (bb[w-1] == ai[w-1]) && (e.sum[w-1] != ai[w-1]);
        e.zero = (e.sum == 32'd0);
        return e;
    endfunction

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z;
        return e;
    endfunction

    task automatic check_result(input int idx, input exp_t e);
        check("sum", sum_o[idx], e.sum);
        check("cout", 32'(cout_o[idx]), 32'(e.cout));
        check("overflow", 32'(ovf_o[idx]), 32'(e.ovf));
        check("zero", 32'(zero_o[idx]), 32'(e.zero));
    endtask

    task automatic check_cleared(input int idx);
        check("rst_busy", 32'(busy_o[idx]), 32'd0);
        check("rst_done", 32'(done_o[idx]), 32'd0);
        check("rst_sum", sum_o[idx], 32'd0);
        check("rst_cout", 32'(cout_o[idx]), 32'd0);
        check("rst_ovf", 32'(ovf_o[idx]), 32'd0);
        check("rst_zero", 32'(zero_o[idx]), 32'd0);
    endtask

    // One transaction on instance idx; disturb pulses start and scrambles inputs mid-RUN
    task automatic op(input int idx, input logic [31:0] ai, input logic [31:0] bi,
                      input logic ci, input logic si, input exp_t e, input bit disturb);
        int   cyc;
        bit   busy_ok;
        exp_t got;
        @(negedge clk);
        a = ai; b = bi; cin = ci; sub = si;
        start_v[idx] = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start_v[idx] = 1'b0;
        cyc = 1;
        busy_ok = 1'b1;
        while (done_o[idx] !== 1'b1 && cyc < 100) begin
            if (busy_o[idx] !== 1'b1) busy_ok = 1'b0;
            if (disturb && cyc == 2) begin
                a = $urandom; b = $urandom; sub = ~sub; cin = ~cin;
                start_v[idx] = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (disturb && cyc == 3) start_v[idx] = 1'b0;
        end
        check("latency", 32'(cyc), 32'(N_T[idx] + 1));
        check("busy_during_run", 32'(busy_ok), 32'd1);
        check("busy_with_done", 32'(busy_o[idx]), 32'd0);
        got = sb.pop_front();
        check_result(idx, got);
        @(negedge clk);
        check("done_single_pulse", 32'(done_o[idx]), 32'd0);
        check("busy_after_done", 32'(busy_o[idx]), 32'd0);
        check("sum_held", sum_o[idx], got.sum);
    endtask

    initial begin
        int          cyc;
        int          nd;
        int          dt [3];
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic        rs;
        exp_t        got;

        reset = 1'b1; start_v = '0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 6; i++) check_cleared(i);
        reset = 1'b0;

        // Single-bit full adder truth table
        for (int v = 0; v < 8; v++) begin
            logic x, y, z;
            x = v[2]; y = v[1]; z = v[0];
            op(0, 32'(x), 32'(y), z, 1'b0,
               mk(32'(x ^ y ^ z), (x & y) | (x & z) | (y & z),
                  (x == y) && ((x ^ y ^ z) != x), (x ^ y ^ z) == 1'b0), 1'b0);
        end

        // Carry ripple through all four chunks
        op(1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(32'd0, 1'b1, 1'b0, 1'b1), 1'b0);

        // Subtract and signed overflow on the 8-bit instance
        op(2, 32'h80, 32'h01, 1'b0, 1'b1, mk(32'h7F, 1'b1, 1'b1, 1'b0), 1'b0);
        op(2, 32'h05, 32'h07, 1'b1, 1'b1, mk(32'hFE, 1'b0, 1'b0, 1'b0), 1'b0);
        op(2, 32'h7F, 32'h01, 1'b0, 1'b0, mk(32'h80, 1'b0, 1'b1, 1'b0), 1'b0);

        // Start and operands disturbed mid-RUN must not affect the result
        op(2, 32'h3C, 32'h21, 1'b1, 1'b0, mk(32'h5E, 1'b0, 1'b0, 1'b0), 1'b1);

        // Start held high: back-to-back results every N+1 cycles
        @(negedge clk);
        a = 32'h12; b = 32'h34; cin = 1'b0; sub = 1'b0;
        start_v[2] = 1'b1;
        sb.push_back(mk(32'h46, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk(32'h03, 1'b0, 1'b0, 1'b0));
        sb.push_back(mk(32'h03, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        cyc = 0;
        nd = 0;
        while (nd < 3 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin a = 32'h01; b = 32'h02; end
            if (cyc == 8) check("sum_held_during_rerun", sum_o[2], 32'h46);
            if (done_o[2] === 1'b1) begin
                dt[nd] = cyc;
                nd++;
                check("busy_with_done_b2b", 32'(busy_o[2]), 32'd0);
                got = sb.pop_front();
                check_result(2, got);
                if (nd == 3) start_v[2] = 1'b0;
            end
        end
        check("b2b_done_count", 32'(nd), 32'd3);
        check("b2b_first_latency", 32'(dt[0]), 32'd5);
        check("b2b_period_1", 32'(dt[1] - dt[0]), 32'd5);
        check("b2b_period_2", 32'(dt[2] - dt[1]), 32'd5);
        @(negedge clk);
        check("b2b_done_stop", 32'(done_o[2]), 32'd0);
        check("b2b_busy_stop", 32'(busy_o[2]), 32'd0);
        start_v[2] = 1'b0;

        // Reset two edges into an N=4 run discards everything
        @(negedge clk);
        a = 32'h10; b = 32'h20; cin = 1'b0; sub = 1'b0;
        start_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[2] = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_cleared(2);
        reset = 1'b0;
        op(2, 32'd3, 32'd4, 1'b0, 1'b0, mk(32'd7, 1'b0, 1'b0, 1'b0), 1'b0);

        // Random sweep at WIDTH=32, CHUNK in {1, 4, 32}
        for (int i = 0; i < 1000; i++) begin
            int idx;
            idx = (i % 3 == 0) ? 3 : ((i % 3 == 1) ? 4 : 5);
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(1)); rs = 1'($urandom_range(1));
            if (i % 50 == 0) rb = ra;
            op(idx, ra, rb, rc, rs, ref_model(W_T[idx], ra, rb, rc, rs), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_adder.md
# multicycle_adder

Parametrised, multi-cycle ripple adder/subtractor that generalises the single-bit full adder to WIDTH-bit operands. It processes CHUNK bits per clock over WIDTH/CHUNK cycles through a start/busy/done handshake, and adds subtract mode and status flags. It sits beside the MIPS ALU as a low-area arithmetic unit and as a regression vehicle for the full-adder cell.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH.
- Derived: N = WIDTH/CHUNK, the number of compute cycles.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when the block is idle or in its done cycle.
- sub  in  1  0 = add, 1 = subtract; captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- cin  in  1  carry-in for add; ignored when sub=1. Captured with start.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse; the result is valid.
- sum  out  WIDTH  result; held until the next accepted start.
- cout  out  1  carry-out of the MSB (for sub: 1 = no borrow).
- overflow  out  1  signed (two's-complement) overflow.
- zero  out  1  sum == 0.

## Operation
- One clock domain. Reset is synchronous and active-high.
- States:
  - IDLE: waiting for start.
  - RUN: adding chunks.
  - DONE: single cycle, result presented.
- Transitions:
  - IDLE --start--> RUN.
  - RUN stays for N cycles, then --> DONE.
  - DONE --start--> RUN (back-to-back operation); otherwise DONE --> IDLE.
- On accept:
  - Latch a.
  - Latch B' = sub ? ~b : b.
  - Set carry = sub ? 1 : cin.
  - Clear the chunk counter k.
- Each RUN cycle:
  - {c, s} = A[k*CHUNK +: CHUNK] + B'[k*CHUNK +: CHUNK] + carry, computed with CHUNK+1-bit arithmetic.
  - Write s into the result slice k; carry ← c; k ← k+1.
- On entering DONE:
  - sum is the full result; cout = final carry.
  - overflow = (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]).
  - zero = ~|sum.
- Boundary behaviour:
  - start while in RUN is ignored; a, b, sub and cin changing during RUN have no effect.
  - Results wrap modulo 2^WIDTH.
  - N = 1 (CHUNK = WIDTH) is legal: a single RUN cycle.
- reset at any time, including mid-RUN:
  - Next state is IDLE.
  - busy, done, sum, cout, overflow and zero all go to 0.
  - The partial result is discarded.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, overflow=0, zero=0; state IDLE.
- Let start be accepted at clock edge T.
  - busy = 1 from edge T to edge T+N.
  - done = 1 for exactly the cycle between edges T+N and T+N+1, with sum, cout, overflow and zero valid from edge T+N.
- Latency: N cycles from the accepting edge to done.
- Throughput with back-to-back starts: one result every N+1 cycles.
  - A start accepted in the DONE cycle drives busy=1 and done=0 at the next edge.
  - sum, cout, overflow and zero still hold the previous result until the new DONE.
- Status flags update only on entry to DONE, never mid-RUN.
- busy and done are never high together.

## Test plan
- Exhaustive cross-check, WIDTH=1, CHUNK=1: all 8 combinations of a, b, cin with sub=0.
  - Example: a=1, b=1, cin=1 -> sum=1, cout=1, done exactly 1 cycle after accept.
  - All combinations must match the full-adder truth table.
- Carry ripple across chunks, WIDTH=32, CHUNK=8: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0.
  - Required: sum=0, cout=1, zero=1, overflow=0.
  - busy high for 4 cycles; done at T+4.
- Subtract and signed overflow, WIDTH=8, CHUNK=2:
  - a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, overflow=0.
  - a=0x7F, b=0x01, sub=0 -> sum=0x80, overflow=1.
- Handshake, WIDTH=8, CHUNK=2:
  - start pulsed mid-RUN and operands changed mid-RUN -> result unaffected, no extra done.
  - start held high continuously -> done pulses every 5 cycles.
- Reset mid-operation: assert reset at T+2 of an N=4 run.
  - Next cycle: all outputs 0, state IDLE.
  - A fresh start of 3+4 then yields sum=7 after N cycles.
- Randomised sweep: 1000 random a, b, cin, sub at WIDTH=32 with CHUNK ∈ {1, 4, 32}, compared against a reference model.
